// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per
// clock, MSB chunk first, with unsigned/two's-complement mode and a
// start/busy/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while busy=0
//   Signed_Mode  0 = unsigned, 1 = two's complement (latched on start)
//   A, B         WIDTH-bit operands (latched on start)
//   busy         high while comparing
//   done         one-cycle pulse, result valid
//   Same         A == B
//   A_High       A > B
//   B_High       B > A
module seq_comparator #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned CHUNK      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Same,
    output logic             A_High,
    output logic             B_High
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              signed_q, signed_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              hit_q, hit_d;     // a differing chunk has been seen
    logic              gt_q, gt_d;       // at first difference, A chunk was larger
    logic              same_q, same_d;
    logic              a_high_q, a_high_d;
    logic              b_high_q, b_high_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic              new_hit, new_gt, finish;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            gt_q     <= 1'b0;
            same_q   <= 1'b0;
            a_high_q <= 1'b0;
            b_high_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            gt_q     <= gt_d;
            same_q   <= same_d;
            a_high_q <= a_high_d;
            b_high_q <= b_high_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, chunk compare and result logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        gt_d     = gt_q;
        same_d   = same_q;
        a_high_d = a_high_q;
        b_high_d = b_high_q;

        a_chunk = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
        b_chunk = CHUNK'(b_q >> (int'(idx_q) * CHUNK));
        // Flipping the sign bit maps two's complement onto unsigned ordering
        if (idx_q == IDX_TOP) begin
            a_chunk[CHUNK-1] = a_chunk[CHUNK-1] ^ signed_q;
            b_chunk[CHUNK-1] = b_chunk[CHUNK-1] ^ signed_q;
        end

        new_hit = hit_q | (a_chunk != b_chunk);
        new_gt  = hit_q ? gt_q : (a_chunk > b_chunk);
        finish  = (idx_q == '0) || ((EARLY_EXIT != 0) && new_hit);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    signed_d = Signed_Mode;
                    idx_d    = IDX_TOP;
                    hit_d    = 1'b0;
                    gt_d     = 1'b0;
                    same_d   = 1'b0;
                    a_high_d = 1'b0;
                    b_high_d = 1'b0;
                    state_d  = ST_CMP;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                hit_d = new_hit;
                gt_d  = new_gt;
                // Results stay hidden until done so all three read 0 mid-compare
                if (finish) begin
                    same_d   = ~new_hit;
                    a_high_d = new_hit & new_gt;
                    b_high_d = new_hit & ~new_gt;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CMP);
        done_d = (state_d == ST_DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Same   = same_q;
    assign A_High = a_high_q;
    assign B_High = b_high_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: one early-exit instance and one
// fixed-latency instance share the same stimulus.
module tb_seq_comparator;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_SAME = 3'b100;
    localparam logic [2:0] R_A    = 3'b010;
    localparam logic [2:0] R_B    = 3'b001;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sm;
    logic [19:0] a;
    logic [19:0] b;

    logic busy1, done1, same1, ah1, bh1;
    logic busy0, done0, same0, ah0, bh0;
    logic [2:0] res1, res0;

    int n_tests = 0;
    int n_fail  = 0;

    assign res1 = {same1, ah1, bh1};
    assign res0 = {same0, ah0, bh0};

    seq_comparator #(.WIDTH(20), .CHUNK(4), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .start(start), .Signed_Mode(sm), .A(a), .B(b),
        .busy(busy1), .done(done1), .Same(same1), .A_High(ah1), .B_High(bh1)
    );

    seq_comparator #(.WIDTH(20), .CHUNK(4), .EARLY_EXIT(0)) u_fix (
        .clk(clk), .rst(rst), .start(start), .Signed_Mode(sm), .A(a), .B(b),
        .busy(busy0), .done(done0), .Same(same0), .A_High(ah0), .B_High(bh0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge. Pulses start, then waits (bounded) for done on both
    // instances and checks latency and result. poke re-pulses start with
    // swapped operands mid-compare; hold checks one cycle after done.
    task automatic run_op(input logic [19:0] ta, input logic [19:0] tb_v,
                          input logic tsm, input logic [2:0] exp_res,
                          input int exp_m1, input bit poke, input bit hold,
                          input string name);
        int m1 = 0;
        int m0 = 0;
        logic [2:0] r1 = 3'b111;
        logic [2:0] r0 = 3'b111;
        a = ta; b = tb_v; sm = tsm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({busy1, done1, res1, busy0, done0, res0} !== {1'b1, 1'b0, R_NONE, 1'b1, 1'b0, R_NONE}) begin
            n_fail++;
            $display("FAIL %s start: ee busy/done/res=%b/%b/%b fix=%b/%b/%b, required 1/0/000 each",
                     name, busy1, done1, res1, busy0, done0, res0);
        end
        for (int k = 1; k <= 8 && (m1 == 0 || m0 == 0); k++) begin
            @(negedge clk);
            if (m1 == 0) begin
                if (done1) begin m1 = k; r1 = res1; end
                else begin
                    n_tests++;
                    if (busy1 !== 1'b1 || res1 !== R_NONE) begin
                        n_fail++;
                        $display("FAIL %s ee_midop k=%0d: busy=%b res=%b, required busy=1 res=000",
                                 name, k, busy1, res1);
                    end
                end
            end
            if (m0 == 0) begin
                if (done0) begin m0 = k; r0 = res0; end
                else begin
                    n_tests++;
                    if (busy0 !== 1'b1 || res0 !== R_NONE) begin
                        n_fail++;
                        $display("FAIL %s fix_midop k=%0d: busy=%b res=%b, required busy=1 res=000",
                                 name, k, busy0, res0);
                    end
                end
            end
            if (poke && k == 1) begin start = 1'b1; a = tb_v; b = ta; end
            if (poke && k == 2) begin start = 1'b0; end
        end
        n_tests++;
        if (m1 != exp_m1 || r1 !== exp_res) begin
            n_fail++;
            $display("FAIL %s ee_result: edges=%0d res=%b, required edges=%0d res=%b",
                     name, m1, r1, exp_m1, exp_res);
        end
        n_tests++;
        if (m0 != 5 || r0 !== exp_res) begin
            n_fail++;
            $display("FAIL %s fix_result: edges=%0d res=%b, required edges=5 res=%b",
                     name, m0, r0, exp_res);
        end
        if (hold) begin
            @(negedge clk);
            n_tests++;
            if ({busy1, done1, res1, busy0, done0, res0} !== {1'b0, 1'b0, exp_res, 1'b0, 1'b0, exp_res}) begin
                n_fail++;
                $display("FAIL %s hold: ee busy/done/res=%b/%b/%b fix=%b/%b/%b, required 0/0/%b each",
                         name, busy1, done1, res1, busy0, done0, res0, exp_res);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy1, done1, res1, busy0, done0, res0} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: ee=%b%b%b fix=%b%b%b, required all 0",
                     busy1, done1, res1, busy0, done0, res0);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy1, done1, res1, busy0, done0, res0} !== 10'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ee=%b%b%b fix=%b%b%b, required all 0",
                     busy1, done1, res1, busy0, done0, res0);
        end
    endtask

    task automatic test_basic;
        run_op(20'h00003, 20'h00002, 1'b0, R_A, 5, 1'b0, 1'b1, "a3_b2");
    endtask

    task automatic test_extremes;
        run_op(20'hFFFFF, 20'h00000, 1'b0, R_A,    1, 1'b0, 1'b1, "ff_0_uns");
        run_op(20'hFFFFF, 20'h00000, 1'b1, R_B,    1, 1'b0, 1'b1, "ff_0_sgn");
        run_op(20'hFFFFF, 20'hFFFFF, 1'b0, R_SAME, 5, 1'b0, 1'b1, "ff_eq_uns");
        run_op(20'hFFFFF, 20'hFFFFF, 1'b1, R_SAME, 5, 1'b0, 1'b1, "ff_eq_sgn");
        run_op(20'h00000, 20'h00000, 1'b0, R_SAME, 5, 1'b0, 1'b1, "zero_eq_uns");
        run_op(20'h00000, 20'h00000, 1'b1, R_SAME, 5, 1'b0, 1'b1, "zero_eq_sgn");
        run_op(20'h80000, 20'h7FFFF, 1'b0, R_A,    1, 1'b0, 1'b1, "min_max_uns");
        run_op(20'h80000, 20'h7FFFF, 1'b1, R_B,    1, 1'b0, 1'b1, "min_max_sgn");
        run_op(20'h12345, 20'h12355, 1'b0, R_B,    4, 1'b0, 1'b1, "mid_chunk");
        run_op(20'hFFFFE, 20'hFFFFF, 1'b1, R_B,    5, 1'b0, 1'b1, "neg_low_chunk");
    endtask

    task automatic test_busy_ignore;
        run_op(20'h00003, 20'h00002, 1'b0, R_A, 5, 1'b1, 1'b1, "start_while_busy");
    endtask

    task automatic test_back_to_back;
        run_op(20'h00003, 20'h00002, 1'b0, R_A, 5, 1'b0, 1'b0, "b2b_first");
        run_op(20'h00000, 20'h00001, 1'b0, R_B, 5, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid_cmp;
        bit saw_done = 1'b0;
        a = 20'h00003; b = 20'h00002; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy1, done1, res1, busy0, done0, res0} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_cmp: ee=%b%b%b fix=%b%b%b, required all 0",
                     busy1, done1, res1, busy0, done0, res0);
        end
        repeat (7) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: activity_after_reset=%b, required 0", saw_done);
        end
        run_op(20'h00002, 20'h00003, 1'b0, R_B, 5, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_cmp;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
